button_event_queue: RTL

BUTTON_EVENT_QUEUE -- requirements
Module: button_event_queue

---
 rtl/button_event_queue.sv | 151 +++++++++++++++
 1 files changed

// File: rtl/button_event_queue.sv
// Button press event queue: turns debounced button levels into press events
// (lowest index first) and buffers them in a show-ahead FIFO.
// Optional auto-repeat for a single held button is enabled by AUTOREPEAT_EN.
module button_event_queue #(
  parameter int unsigned DEPTH        = 4,
  parameter int unsigned REPEAT_DELAY = 25_000_000,
  parameter int unsigned REPEAT_RATE  = 5_000_000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] btn_clean,
  input  logic       evt_ready,
  output logic       evt_valid,
  output logic [2:0] evt_code,
  output logic       evt_repeat,
  output logic       overflow
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;
`ifdef AUTOREPEAT_EN
  localparam int unsigned ENTRY_W = 4;  // {repeat, code}
  localparam int unsigned HOLD_W  = 25;
`else
  localparam int unsigned ENTRY_W = 3;  // {code}
`endif

  logic [7:0]         btn_prev;
  logic [7:0]         press_pending;
  logic [7:0]         press_edge;
  logic [7:0]         clr_mask;
  logic [ENTRY_W-1:0] mem [DEPTH];
  logic [ENTRY_W-1:0] head;
  logic [ENTRY_W-1:0] push_data;
  logic [PTR_W-1:0]   wr_ptr;
  logic [PTR_W-1:0]   rd_ptr;
  logic [CNT_W-1:0]   count;
  logic               fifo_full;
  logic               do_pop;
  logic               can_push;
  logic               push;
  logic               push_press;
  logic               pp_any;
  logic [2:0]         pp_idx;

  assign press_edge = btn_clean & ~btn_prev;
  assign fifo_full  = (count == CNT_W'(DEPTH));
  assign evt_valid  = (count != CNT_W'(0));
  assign do_pop     = evt_valid & evt_ready;
  // A pop in the same cycle frees the slot the push needs.
  assign can_push   = ~fifo_full | do_pop;
  assign push_press = can_push & pp_any;
  assign head       = mem[rd_ptr];
  assign evt_code   = evt_valid ? head[2:0] : 3'd0;

  // Lowest-index pending press and the bit to clear when it is pushed.
  always_comb begin
    pp_any   = 1'b0;
    pp_idx   = 3'd0;
    clr_mask = 8'd0;
    for (int i = 7; i >= 0; i--) begin
      if (press_pending[i]) begin
        pp_any = 1'b1;
        pp_idx = 3'(i);
      end
    end
    if (push_press) clr_mask[pp_idx] = 1'b1;
  end

`ifdef AUTOREPEAT_EN
  logic [HOLD_W-1:0] hold_cnt;
  logic [HOLD_W-1:0] hold_next;
  logic              rpt_pending;
  logic [2:0]        rpt_code;
  logic [2:0]        held_idx;
  logic              one_hot;
  logic              hold_run;
  logic              rpt_req;
  logic              push_rpt;

  assign one_hot   = (btn_clean != 8'd0) && ((btn_clean & (btn_clean - 8'd1)) == 8'd0);
  assign hold_run  = one_hot && (btn_clean == btn_prev);
  assign hold_next = hold_cnt + HOLD_W'(1);
  assign rpt_req   = hold_run && (hold_next == HOLD_W'(REPEAT_DELAY));
  assign push_rpt  = can_push & ~pp_any & rpt_pending;
  assign push      = push_press | push_rpt;
  assign push_data = push_press ? {1'b0, pp_idx} : {1'b1, rpt_code};
  assign evt_repeat = evt_valid & head[3];

  // Index of the single held button.
  always_comb begin
    held_idx = 3'd0;
    for (int i = 0; i < 8; i++) begin
      if (btn_clean[i]) held_idx = 3'(i);
    end
  end

  // Hold counter; after the first repeat it reloads so the next request
  // lands REPEAT_RATE cycles later (assumes REPEAT_DELAY >= REPEAT_RATE).
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hold_cnt    <= '0;
      rpt_pending <= 1'b0;
      rpt_code    <= 3'd0;
    end else if (!hold_run) begin
      hold_cnt    <= '0;
      rpt_pending <= 1'b0;
    end else if (rpt_req) begin
      hold_cnt    <= HOLD_W'(REPEAT_DELAY - REPEAT_RATE);
      rpt_pending <= 1'b1;
      if (!rpt_pending || push_rpt) rpt_code <= held_idx;
    end else begin
      hold_cnt <= hold_next;
      if (push_rpt) rpt_pending <= 1'b0;
    end
  end
`else
  assign push       = push_press;
  assign push_data  = pp_idx;
  assign evt_repeat = 1'b0;
`endif

  // Edge capture, pending presses, overflow flag and FIFO pointers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      btn_prev      <= 8'd0;
      press_pending <= 8'd0;
      overflow      <= 1'b0;
      wr_ptr        <= '0;
      rd_ptr        <= '0;
      count         <= '0;
    end else begin
      btn_prev      <= btn_clean;
      press_pending <= (press_pending & ~clr_mask) | (press_edge & ~press_pending);
      if ((press_edge & press_pending) != 8'd0) overflow <= 1'b1;
      if (push)   wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_pop) rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, do_pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // FIFO storage; contents are only visible through evt_valid gating.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= push_data;
  end

endmodule
